// File: rtl/npc_fetch.sv
// Instruction-fetch front end: computes NPC, drives the instruction SRAM, presents IF.
// Optional FETCH_ADEL_EN flags misaligned fetch addresses and masks the word to a nop.
module npc_fetch #(
  parameter logic [31:0] RESET_VEC = 32'hbfc00000,
  parameter logic [31:0] EXC_VEC   = 32'hbfc00380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC,
  input  logic        PC_write,
  input  logic        exc_valid,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        id_is_branch,
  output logic        inst_sram_en,
  output logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_rdata,
  output logic [31:0] NPC,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid,
  output logic        if_in_delay_slot,
  output logic        if_adel
);

  logic        load;
  logic [31:0] pc_plus4;
  logic [31:0] npc_d;
  logic [31:0] raw_inst;

  logic        boot_q,    boot_d;
  logic        hold_v_q,  hold_v_d;
  logic [31:0] hold_q,    hold_d;
  logic        br_pend_q, br_pend_d;
  logic [31:0] br_tgt_q,  br_tgt_d;

  // pc takes NPC under exactly this condition, so every fetch state change keys off it.
  assign load     = PC_write | exc_valid;
  assign pc_plus4 = PC + 32'd4;

  always_comb begin
    if (exc_valid)      npc_d = EXC_VEC;
    else if (eret)      npc_d = epc;
    else if (br_taken)  npc_d = br_target;
    else if (br_pend_q) npc_d = br_tgt_q;
    else                npc_d = pc_plus4;
  end

  always_comb begin
    boot_d    = boot_q & ~load;
    hold_v_d  = hold_v_q;
    hold_d    = hold_q;
    br_pend_d = br_pend_q;
    br_tgt_d  = br_tgt_q;
    // The SRAM output is only trustworthy on the first stall cycle; latch it there.
    if (load) begin
      hold_v_d = 1'b0;
    end else if (!hold_v_q) begin
      hold_v_d = 1'b1;
      hold_d   = inst_sram_rdata;
    end
    // exc_valid implies load, so an exception always wins over a capture.
    if (load) begin
      br_pend_d = 1'b0;
    end else if (br_taken) begin
      br_pend_d = 1'b1;
      br_tgt_d  = br_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      boot_q    <= 1'b1;
      hold_v_q  <= 1'b0;
      hold_q    <= 32'h0;
      br_pend_q <= 1'b0;
      br_tgt_q  <= 32'h0;
    end else begin
      boot_q    <= boot_d;
      hold_v_q  <= hold_v_d;
      hold_q    <= hold_d;
      br_pend_q <= br_pend_d;
      br_tgt_q  <= br_tgt_d;
    end
  end

  assign NPC              = npc_d;
  assign inst_sram_en     = load;
  assign inst_sram_addr   = npc_d;
  assign raw_inst         = hold_v_q ? hold_q : inst_sram_rdata;
  assign if_pc            = PC;
  assign if_valid         = ~boot_q & ~exc_valid;
  assign if_in_delay_slot = id_is_branch & if_valid;

`ifdef FETCH_ADEL_EN
  logic misaligned;
  assign misaligned = |PC[1:0];
  assign if_adel    = if_valid & misaligned;
  assign if_inst    = if_adel ? 32'h0 : raw_inst;
`else
  assign if_adel    = 1'b0;
  assign if_inst    = raw_inst;
`endif

endmodule

// File: tb/tb_npc_fetch.sv
module tb_npc_fetch;

  localparam logic [31:0] B   = 32'hbfc00000;
  localparam logic [31:0] EXC = 32'hbfc00380;
`ifdef FETCH_ADEL_EN
  localparam bit ADEL_ON = 1'b1;
`else
  localparam bit ADEL_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC;
  logic        PC_write, exc_valid, eret, br_taken, id_is_branch;
  logic [31:0] epc, br_target;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata = 32'h0;
  logic [31:0] NPC, if_pc, if_inst;
  logic        if_valid, if_in_delay_slot, if_adel;

  int checks = 0;
  int errors = 0;
  logic [15:0] cyc = 16'h0;

  always #5 clk = ~clk;

  npc_fetch dut (
    .clk(clk), .rst(rst), .PC(PC), .PC_write(PC_write), .exc_valid(exc_valid),
    .eret(eret), .epc(epc), .br_taken(br_taken), .br_target(br_target),
    .id_is_branch(id_is_branch), .inst_sram_en(inst_sram_en),
    .inst_sram_addr(inst_sram_addr), .inst_sram_rdata(inst_sram_rdata),
    .NPC(NPC), .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid),
    .if_in_delay_slot(if_in_delay_slot), .if_adel(if_adel)
  );

  function automatic logic [31:0] mf(input logic [31:0] a);
    return a ^ 32'h5a5aa5a5;
  endfunction

  // SRAM model: one-cycle read; outputs junk when not enabled so stale reads are visible.
  always @(posedge clk) begin
    cyc <= cyc + 16'd1;
    if (inst_sram_en) inst_sram_rdata <= mf(inst_sram_addr);
    else              inst_sram_rdata <= {16'hdead, cyc};
  end

  typedef struct {
    logic [31:0] pc;
    logic        pw, exc, er;
    logic [31:0] epc;
    logic        bt;
    logic [31:0] bta;
    logic        isbr;
    logic [31:0] npc;
    logic        en, vld, mis, ci;
    logic [31:0] inst;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [31:0] pc, input logic pw, exc, er, input logic [31:0] e,
                     input logic bt, input logic [31:0] bta, input logic isbr,
                     input logic [31:0] npc, input logic en, vld, mis, ci,
                     input logic [31:0] inst);
    vec_t v;
    v.pc = pc; v.pw = pw; v.exc = exc; v.er = er; v.epc = e; v.bt = bt; v.bta = bta;
    v.isbr = isbr; v.npc = npc; v.en = en; v.vld = vld; v.mis = mis; v.ci = ci; v.inst = inst;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic pw, exc, er, input logic [31:0] e,
                       input logic bt, input logic [31:0] bta, input logic isbr);
    PC = pc; PC_write = pw; exc_valid = exc; eret = er; epc = e;
    br_taken = bt; br_target = bta; id_is_branch = isbr;
  endtask

  initial begin
    // pc, pw, exc, eret, epc, bt, bta, isbr | npc, en, vld, mis, chk_inst, inst
    add(B-4,     1,0,0,0,0,0,0,     B,       1,0,0,0,0);
    add(B,       1,0,0,0,0,0,0,     B+4,     1,1,0,1,mf(B));
    add(B+4,     1,0,0,0,0,0,0,     B+8,     1,1,0,1,mf(B+4));
    add(B+8,     1,0,0,0,0,0,0,     B+'hc,   1,1,0,1,mf(B+8));
    add(B+'hc,   1,0,0,0,0,0,0,     B+'h10,  1,1,0,1,mf(B+'hc));
    add(B+'h10,  0,0,0,0,0,0,0,     B+'h14,  0,1,0,1,mf(B+'h10));
    add(B+'h10,  0,0,0,0,0,0,0,     B+'h14,  0,1,0,1,mf(B+'h10));
    add(B+'h10,  0,0,0,0,0,0,0,     B+'h14,  0,1,0,1,mf(B+'h10));
    add(B+'h10,  1,0,0,0,0,0,0,     B+'h14,  1,1,0,1,mf(B+'h10));
    add(B+'h14,  1,0,0,0,0,0,0,     B+'h18,  1,1,0,1,mf(B+'h14));
    add(B+'h18,  0,0,0,0,1,B+'h100,0, B+'h100, 0,1,0,1,mf(B+'h18));
    add(B+'h18,  0,0,0,0,0,0,0,     B+'h100, 0,1,0,1,mf(B+'h18));
    add(B+'h18,  1,0,0,0,0,0,0,     B+'h100, 1,1,0,1,mf(B+'h18));
    add(B+'h100, 1,0,0,0,0,0,0,     B+'h104, 1,1,0,1,mf(B+'h100));
    add(B+'h104, 1,0,0,0,0,0,0,     B+'h108, 1,1,0,1,mf(B+'h104));
    add(B+'h108, 0,1,0,0,1,B+'h200,1, EXC,   1,0,0,1,mf(B+'h108));
    add(EXC,     0,0,1,B+'h20,0,0,0, B+'h20, 0,1,0,1,mf(EXC));
    add(EXC,     0,0,0,0,0,0,0,     EXC+4,   0,1,0,1,mf(EXC));
    add(EXC,     1,0,1,B+'h20,0,0,0, B+'h20, 1,1,0,1,mf(EXC));
    add(B+'h20,  1,0,0,0,1,B+'h102,1, B+'h102, 1,1,0,1,mf(B+'h20));
    add(B+'h102, 1,0,0,0,0,0,0,     B+'h106, 1,1,1,1,mf(B+'h102));
    add(B+'h106, 1,0,0,0,0,0,0,     B+'h10a, 1,1,1,1,mf(B+'h106));
    add(32'hfffffffc, 1,0,0,0,0,0,0, 32'h0,  1,1,0,0,0);
    add(32'h0,   1,1,1,B+'h20,0,0,0, EXC,    1,0,0,1,mf(32'h0));

    rst = 1'b0;
    drive(B-4, 1,0,0,0,0,0,0);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("reset_npc",   NPC, B);
    chk("reset_en",    {31'h0, inst_sram_en}, 32'h1);
    chk("reset_valid", {31'h0, if_valid}, 32'h0);
    chk("reset_adel",  {31'h0, if_adel}, 32'h0);

    foreach (vq[i]) begin
      logic exp_adel;
      @(posedge clk); #1;
      rst = 1'b1;
      drive(vq[i].pc, vq[i].pw, vq[i].exc, vq[i].er, vq[i].epc, vq[i].bt, vq[i].bta, vq[i].isbr);
      @(negedge clk);
      exp_adel = ADEL_ON & vq[i].mis & vq[i].vld;
      chk($sformatf("v%0d_npc", i),   NPC, vq[i].npc);
      chk($sformatf("v%0d_addr", i),  inst_sram_addr, vq[i].npc);
      chk($sformatf("v%0d_en", i),    {31'h0, inst_sram_en}, {31'h0, vq[i].en});
      chk($sformatf("v%0d_valid", i), {31'h0, if_valid}, {31'h0, vq[i].vld});
      chk($sformatf("v%0d_ds", i),    {31'h0, if_in_delay_slot}, {31'h0, vq[i].isbr & vq[i].vld});
      chk($sformatf("v%0d_adel", i),  {31'h0, if_adel}, {31'h0, exp_adel});
      chk($sformatf("v%0d_pc", i),    if_pc, vq[i].pc);
      if (vq[i].ci)
        chk($sformatf("v%0d_inst", i), if_inst, exp_adel ? 32'h0 : vq[i].inst);
    end

    // Reset mid-stall with a redirect pending and a held word: all of it must vanish.
    @(posedge clk); #1;
    drive(B+'h54, 0,0,0,0,1,B+'h300,0);
    @(posedge clk); #1;
    drive(B+'h54, 0,0,0,0,0,0,0);
    @(negedge clk);
    chk("pend_before_reset", NPC, B+'h300);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(B-4, 1,0,0,0,0,0,0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midreset_npc", NPC, B);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset_npc",   NPC, B);
    chk("post_reset_valid", {31'h0, if_valid}, 32'h0);
    chk("post_reset_inst",  if_inst, mf(B));
    @(posedge clk); #1;
    drive(B, 1,0,0,0,0,0,0);
    @(negedge clk);
    chk("boot1_valid", {31'h0, if_valid}, 32'h1);
    chk("boot1_npc",   NPC, B+4);
    chk("boot1_inst",  if_inst, mf(B));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
